// File: rtl/muldiv_pkg.sv
// Shared encodings, state type and sizing helper for the multiply/divide unit.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_RUN,
    ST_FIX,
    ST_DONE
  } state_e;

  // Width of the iteration counter that runs 0..width-1.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial subtract, keep if non-negative.
module muldiv_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] divisor,
  input  logic             bit_in,
  output logic [WIDTH-1:0] rem_next_c,
  output logic             q_bit_c
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Borrow out of the (WIDTH+1)-bit subtract means the trial went negative.
  always_comb begin
    shifted    = {rem, bit_in};
    diff       = shifted - {1'b0, divisor};
    q_bit_c    = ~diff[WIDTH];
    rem_next_c = q_bit_c ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle signed/unsigned multiply and divide with start/busy/done handshake.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter bit          SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam int unsigned AW = 2 * WIDTH;

  state_e           state_q, state_d;
  logic             busy_d, done_d, dz_d;

  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [AW-1:0]    acc_q;
  logic [CW-1:0]    cnt_q;
  logic             neg_res_q, neg_rem_q;

  logic             is_div, is_signed;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   sum;
  logic [AW-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  logic [WIDTH-1:0] rem_next_c;
  logic             q_bit_c;

  // Operand decode, magnitudes, shift-add sum and sign fix-up of the finished result.
  always_comb begin
    is_div    = op_q[1];
    is_signed = SIGNED_EN && ((op_q == OP_MULT) || (op_q == OP_DIV));
    mag_a     = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
    mag_b     = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;
    sum       = {1'b0, acc_q[AW-1:WIDTH]} + {1'b0, (b_q[0] ? a_q : '0)};
    prod_fix  = neg_res_q ? -acc_q : acc_q;
    quo_fix   = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix   = neg_rem_q ? -acc_q[AW-1:WIDTH] : acc_q[AW-1:WIDTH];
  end

  // Dividend bits enter from the top of a_q; remainder lives in the upper accumulator half.
  muldiv_div_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .rem       (acc_q[AW-1:WIDTH]),
    .divisor   (b_q),
    .bit_in    (a_q[WIDTH-1]),
    .rem_next_c(rem_next_c),
    .q_bit_c   (q_bit_c)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake decode; a DONE entered straight from PREP is a divide by zero.
  always_comb begin
    state_d = state_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    dz_d    = 1'b0;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_PREP;
      ST_PREP: begin
        if (cancel)                     state_d = ST_IDLE;
        else if (is_div && (b_q == '0)) state_d = ST_DONE;
        else                            state_d = ST_RUN;
      end
      ST_RUN: begin
        if (cancel)                          state_d = ST_IDLE;
        else if (cnt_q == CW'(WIDTH - 1))    state_d = ST_FIX;
      end
      ST_FIX:  state_d = cancel ? ST_IDLE : ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    dz_d   = done_d && (state_q == ST_PREP);
  end

  // Registered handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      busy     <= busy_d;
      done     <= done_d;
      div_zero <= dz_d;
    end
  end

  // Operand capture, iteration datapath and result write-back.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_q <= op;
            a_q  <= a;
            b_q  <= b;
          end
        end
        ST_PREP: begin
          a_q       <= mag_a;
          b_q       <= mag_b;
          neg_res_q <= is_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          neg_rem_q <= is_signed && a_q[WIDTH-1];
          acc_q     <= '0;
          cnt_q     <= '0;
        end
        ST_RUN: begin
          cnt_q <= cnt_q + CW'(1);
          if (is_div) begin
            acc_q <= {rem_next_c, acc_q[WIDTH-2:0], q_bit_c};
            a_q   <= {a_q[WIDTH-2:0], 1'b0};
          end else begin
            acc_q <= {sum, acc_q[WIDTH-1:1]};
            b_q   <= {1'b0, b_q[WIDTH-1:1]};
          end
        end
        ST_FIX: begin
          if (state_d == ST_DONE) begin
            if (is_div) begin
              hi <= rem_fix;
              lo <= quo_fix;
            end else begin
              hi <= prod_fix[AW-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised bench for muldiv_unit against a cycle-level behavioural model.
module tb_muldiv_unit;

  localparam int unsigned W = 32;

  logic         clk    = 1'b0;
  logic         reset  = 1'b0;
  logic         start  = 1'b0;
  logic         cancel = 1'b0;
  logic [1:0]   op     = 2'b00;
  logic [W-1:0] a      = '0;
  logic [W-1:0] b      = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  muldiv_unit #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .done(done), .div_zero(div_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_word(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: {hi, lo} from plain 64-bit math.
  function automatic logic [2*W-1:0] ref_calc(input logic [1:0] o, input logic [W-1:0] x,
                                              input logic [W-1:0] y);
    longint       sx, sy;
    logic [63:0]  r;
    logic [W-1:0] q, rm;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: r = sx * sy;
      2'b01: r = {32'h0, x} * {32'h0, y};
      2'b10: begin q = W'(sx / sy); rm = W'(sx % sy); r = {rm, q}; end
      default: begin q = x / y; rm = x % y; r = {rm, q}; end
    endcase
    return r;
  endfunction

  // Behavioural model: k counts edges since start was taken; DONE is entered at edge len.
  bit           m_active = 1'b0;
  bit           m_dz     = 1'b0;
  int           m_k      = 0;
  int           m_len    = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0, r_hi = '0, r_lo = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active = 1'b0;
      m_k      = 0;
      m_hi     = '0;
      m_lo     = '0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1'b1;
        m_k      = 0;
        m_dz     = op[1] && (b == '0);
        m_len    = m_dz ? 1 : W + 2;
        if (!m_dz) {r_hi, r_lo} = ref_calc(op, a, b);
      end
    end else if (m_k < m_len && cancel) begin
      m_active = 1'b0;
    end else begin
      m_k++;
      if (m_k == m_len && !m_dz) begin
        m_hi = r_hi;
        m_lo = r_lo;
      end
      if (m_k == m_len + 1) m_active = 1'b0;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (reset && cmp_en) begin
      chk_bit("busy", busy, m_active);
      chk_bit("done", done, m_active && (m_k == m_len));
      chk_bit("div_zero", div_zero, m_active && (m_k == m_len) && m_dz);
      chk_word("hi", hi, m_hi);
      chk_word("lo", lo, m_lo);
    end
  end

  // mode: 0 plain, 1 start pulsed while busy, 2 cancel at RUN count 10, 3 reset mid-RUN.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int mode, input bit lit,
                        input logic [W-1:0] eh, input logic [W-1:0] el);
    bit seen;
    int exp_lat;
    exp_lat = (o[1] && (y == '0)) ? 1 : W + 2;
    seen    = 1'b0;
    @(negedge clk);
    #1;
    start = 1'b1; op = o; a = x; b = y;
    for (int n = 0; n < W + 10; n++) begin
      @(negedge clk);
      if (done) begin
        if (!seen) begin
          chk_int("latency", n, exp_lat);
          chk_bit("dz_flag", div_zero, o[1] && (y == '0));
        end
        seen = 1'b1;
      end
      #1;
      if (n == 0) begin
        start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
      end
      if (mode == 1 && n == 5) start = 1'b1;
      if (mode == 1 && n == 6) start = 1'b0;
      if (mode == 2 && n == 11) cancel = 1'b1;
      if (mode == 2 && n == 12) begin
        cancel = 1'b0;
        chk_bit("cancel_busy", busy, 1'b0);
        break;
      end
      if (mode == 3 && n == 15) begin
        #1 reset = 1'b0;
        #1;
        chk_bit("rst_busy", busy, 1'b0);
        chk_bit("rst_done", done, 1'b0);
        chk_word("rst_hi", hi, '0);
        chk_word("rst_lo", lo, '0);
        @(negedge clk);
        #1 reset = 1'b1;
        break;
      end
      if (!busy && n > 0) break;
    end
    if (mode <= 1) chk_bit("done_seen", seen, 1'b1);
    if (mode == 2) begin
      repeat (3) begin
        @(negedge clk);
        chk_bit("cancel_no_done", done, 1'b0);
      end
    end
    if (lit) begin
      chk_word("lit_hi", hi, eh);
      chk_word("lit_lo", lo, el);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]   ro;
    logic [W-1:0] rx, ry;
    int           sel;

    repeat (3) @(negedge clk);
    chk_bit("reset_busy", busy, 1'b0);
    chk_bit("reset_done", done, 1'b0);
    chk_bit("reset_dz", div_zero, 1'b0);
    chk_word("reset_hi", hi, '0);
    chk_word("reset_lo", lo, '0);
    #1 reset = 1'b1;
    cmp_en = 1'b1;

    run_op(2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b1, 32'h0000_0000, 32'h0000_0001);
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op(2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 0, 1'b1, 32'h0000_0001, 32'h7FFF_FFFC);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1, 32'h0000_0000, 32'h8000_0000);
    run_op(2'b11, 32'h0000_0005, 32'h0000_0002, 0, 1'b1, 32'h0000_0001, 32'h0000_0002);
    run_op(2'b10, 32'h0000_0005, 32'h0000_0000, 0, 1'b1, 32'h0000_0001, 32'h0000_0002);
    run_op(2'b01, 32'h0000_0007, 32'h0000_0009, 1, 1'b1, 32'h0000_0000, 32'h0000_003F);
    run_op(2'b11, 32'h0000_0064, 32'h0000_0007, 2, 1'b1, 32'h0000_0000, 32'h0000_003F);

    for (int i = 0; i < 150; i++) begin
      ro  = 2'($urandom_range(0, 3));
      rx  = $urandom;
      ry  = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0: ry = '0;
        1: begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
        2: ry = 32'h0000_0001;
        3: ry = ry >> $urandom_range(0, 31);
        default: ;
      endcase
      run_op(ro, rx, ry, 0, 1'b0, '0, '0);
    end

    run_op(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 3, 1'b1, 32'h0000_0000, 32'h0000_0000);
    run_op(2'b01, 32'h0000_0003, 32'h0000_0004, 0, 1'b1, 32'h0000_0000, 32'h0000_000C);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide unit; successor to the current multiply-only unit.
- Adds signed and unsigned divide, a generic WIDTH, cancel, and divide-by-zero detection.
- Sits beside the ALU. Operands come from the A/B registers; results go to the HI/LO registers.
- Talks to the control unit through a start/busy/done handshake.

Parameters:
- WIDTH, 32, operand width in bits; any value ≥ 4. hi and lo are each WIDTH bits.
- SIGNED_EN, 1, when 0 the signed ops MULT and DIV behave exactly like MULTU and DIVU.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (reset=0 resets immediately, independent of clk).
- start  in  1  request; sampled only in IDLE.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  in  WIDTH  multiplicand / dividend.
- b  in  WIDTH  multiplier / divisor.
- cancel  in  1  abort the operation in progress.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- div_zero  out  1  one-cycle pulse, coincident with done, on a divide by zero.
- hi  out  WIDTH  product high half / remainder.
- lo  out  WIDTH  product low half / quotient.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE and the iteration counter clears.
  - busy, done and div_zero go to 0; hi and lo go to 0.
  - Takes effect mid-operation too; no partial result is ever written.
- States: IDLE, PREP, RUN, FIX, DONE.
- IDLE:
  - start=1 at a rising edge latches op, a and b; the state moves to PREP.
  - Later changes on op, a and b are ignored until the next IDLE.
- PREP (1 cycle):
  - Takes absolute values of the operands for signed ops.
  - Records the result sign and the dividend sign.
  - Clears the accumulator.
  - Divide with b==0: go straight to DONE with div_zero set. Otherwise go to RUN.
- RUN (WIDTH cycles; counter runs 0..WIDTH-1):
  - Multiply: one shift-add step per cycle on the unsigned magnitudes; 2·WIDTH-bit accumulator.
  - Divide: one restoring-division step per cycle (shift, trial subtract, keep if non-negative).
- FIX (1 cycle):
  - MULT: negate the 2·WIDTH-bit product if the operand signs differed.
  - DIV: negate the quotient if the signs differed; give the remainder the sign of the dividend.
  - Quotient truncates toward zero.
  - Arithmetic is modulo 2^WIDTH, so most-negative ÷ -1 gives lo=most-negative, hi=0, with no flag.
- DONE (1 cycle):
  - done=1 for this cycle.
  - hi and lo are written on the edge that enters DONE. A divide by zero leaves hi and lo unchanged.
  - Next state is always IDLE; start is not accepted in DONE.
- Latency, counted from the edge that samples start (edge 0):
  - Normal op: DONE is entered at edge WIDTH+2, i.e. edge 34 for WIDTH=32.
  - Divide by zero: DONE is entered at edge 1.
- cancel=1 in PREP, RUN or FIX:
  - Next edge goes to IDLE.
  - No done; hi and lo unchanged.
  - cancel is ignored in IDLE and DONE.
- start=1 while busy is ignored and is not queued.
- hi and lo hold their value between operations; only DONE (non-div-zero) or reset changes them.

Decomposition:
- muldiv_pkg holds:
  - the op encodings OP_MULT, OP_MULTU, OP_DIV, OP_DIVU;
  - the state enum;
  - a function giving the counter width, $clog2(WIDTH).
- One sub-module: muldiv_div_step. It is a combinational single restoring-division iteration (remainder, divisor, next dividend bit → new remainder, quotient bit), parametrised by WIDTH.

Test Plan (WIDTH=32):
- MULT a=0xFFFFFFFE, b=0x00000003 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA; done high only in the cycle after edge 34; busy high from edge 0 to edge 35.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. MULT with the same operands -> hi=0, lo=1.
- DIV a=0xFFFFFFF9, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU with the same operands -> lo=0x7FFFFFFC, hi=0x00000001.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
- DIV a=5, b=0 after an earlier result of hi=1/lo=2 -> done and div_zero both pulse in the cycle after edge 1; hi=1 and lo=2 are retained.
- Control cases:
  - start pulsed during RUN -> ignored.
  - cancel at RUN count 10 -> busy=0 after the next edge, no done, hi/lo unchanged.
  - reset=0 mid-RUN -> busy, done, hi and lo go to 0 immediately, without waiting for a clock edge.
